// File: rtl/hififo_stream_framer.sv
// Forwards 64-bit words from the from-PC FIFO to the to-PC FIFO through a 4-entry buffer,
// optionally appending a {seq, MAGIC, checksum} trailer after every FRAME_LEN payload words.
module hififo_stream_framer #(
    parameter int unsigned FRAME_LEN = 256,
    parameter logic [15:0] MAGIC     = 16'hA5C3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] fpc_data,
    input  logic        fpc_valid,
    output logic        fpc_read,
    output logic [63:0] tpc_data,
    output logic        tpc_write,
    input  logic        tpc_ready,
    output logic [15:0] frame_count
);

    typedef enum logic {
        ST_PAYLOAD = 1'b0,
        ST_TRAILER = 1'b1
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    logic [63:0] buf_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  occ_q, occ_d;
    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [31:0] csum_q, csum_d;
    logic [15:0] seq_q, seq_d;
    logic        active_q, active_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [63:0] data_q, data_d;

    logic        push, pop, issue, active_eff;
    logic [63:0] head;

    assign push  = rd_q && fpc_valid;
    assign issue = tpc_ready && ((state_q == ST_TRAILER) || (occ_q != 3'd0));
    assign pop   = issue && (state_q == ST_PAYLOAD);
    assign head  = buf_q[rd_ptr_q];
    // Framing decision is only re-sampled at a frame boundary.
    assign active_eff = ((state_q == ST_PAYLOAD) && (count_q == 16'd0)) ? enable : active_q;

    always_comb begin
        occ_d    = occ_q + 3'(push) - 3'(pop);
        // Occupancy <= 2 leaves room for the word a registered read may still bring in.
        rd_d     = (occ_d <= 3'd2);
        wr_d     = issue;
        data_d   = data_q;
        state_d  = state_q;
        count_d  = count_q;
        csum_d   = csum_q;
        seq_d    = seq_q;
        active_d = active_eff;
        if (issue) begin
            if (state_q == ST_TRAILER) begin
                data_d  = {seq_q, MAGIC, csum_q};
                seq_d   = seq_q + 16'd1;
                csum_d  = 32'd0;
                count_d = 16'd0;
                state_d = ST_PAYLOAD;
            end else begin
                data_d = head;
                if (active_eff) begin
                    csum_d  = csum_q + head[63:32] + head[31:0];
                    count_d = count_q + 16'd1;
                    if (count_q == LAST_IDX) begin
                        state_d = ST_TRAILER;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_q[wr_ptr_q] <= fpc_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 3'd0;
            state_q  <= ST_PAYLOAD;
            count_q  <= 16'd0;
            csum_q   <= 32'd0;
            seq_q    <= 16'd0;
            active_q <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            data_q   <= 64'd0;
        end else begin
            wr_ptr_q <= wr_ptr_q + 2'(push);
            rd_ptr_q <= rd_ptr_q + 2'(pop);
            occ_q    <= occ_d;
            state_q  <= state_d;
            count_q  <= count_d;
            csum_q   <= csum_d;
            seq_q    <= seq_d;
            active_q <= active_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            data_q   <= data_d;
        end
    end

    assign fpc_read    = rd_q;
    assign tpc_write   = wr_q;
    assign tpc_data    = data_q;
    assign frame_count = seq_q;

endmodule
